// File: rtl/apb_sram_ctrl.sv
// rtl/apb_sram_ctrl.sv - APB4 slave front-end for a single-port SRAM with a bounded read wait
module apb_sram_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 8,
    parameter  int TIMEOUT    = 15,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int OFS        = $clog2(STRB_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDR_WIDTH+OFS-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [STRB_WIDTH-1:0]     pstrb,
    input  logic [2:0]                pprot,
    output logic                      pready,
    output logic                      pslverr,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic                      read,
    output logic                      write,
    output logic [STRB_WIDTH-1:0]     byte_strb,
    output logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic                      rvalid
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RWAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic setup;
    logic misaligned;
    logic timeout_hit;
    logic unused_pprot;

    assign setup        = psel && !penable;
    assign misaligned   = |paddr[OFS-1:0];
    // RWAIT lasts at most TIMEOUT cycles; rvalid on the last one still wins.
    assign timeout_hit  = (cnt_q == CNT_LAST);
    assign unused_pprot = ^pprot;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    if (misaligned) begin
                        state_d = S_ERR;
                    end else if (pwrite) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_WR:    state_d = S_DONE;
            S_RD:    state_d = S_RWAIT;
            S_RWAIT: begin
                if (rvalid) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        read    = 1'b0;
        write   = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        case (state_q)
            S_WR:   write = 1'b1;
            S_RD:   read  = 1'b1;
            S_DONE: pready = 1'b1;
            S_ERR: begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end
            default: ;
        endcase
    end

    // Request fields are latched once in IDLE, so the APB side may change freely afterwards.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prdata_d = prdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    addr_d  = paddr[ADDR_WIDTH+OFS-1:OFS];
                    wdata_d = pwdata;
                    strb_d  = pwrite ? pstrb : '0;
                    if (misaligned && !pwrite) begin
                        prdata_d = '0;
                    end
                end
            end
            S_RD: cnt_d = '0;
            S_RWAIT: begin
                if (rvalid) begin
                    prdata_d = rdata;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (timeout_hit) begin
                        prdata_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
        end
    end

    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign byte_strb = strb_q;
    assign prdata    = prdata_q;

endmodule

// File: doc/apb_sram_ctrl.md
APB_SRAM_CTRL -- requirements
Module: apb_sram_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning APB/SRAM data width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning SRAM word-address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles for rvalid.
REQ-004 SHALL derive the localparams STRB_WIDTH = DATA_WIDTH/8 and OFS = log2(STRB_WIDTH).
REQ-005 SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports psel, penable and pwrite, each input, 1 bit: APB4 control.
REQ-008 SHALL have port paddr, input, ADDR_WIDTH+OFS bits: byte address.
REQ-009 SHALL have ports pwdata (input, DATA_WIDTH bits) and pstrb (input, STRB_WIDTH bits).
REQ-010 SHALL have port pprot, input, 3 bits: ignored.
REQ-011 SHALL have ports pready (output, 1 bit), pslverr (output, 1 bit) and prdata (output, DATA_WIDTH bits).
REQ-012 SHALL have port addr, output, ADDR_WIDTH bits: SRAM word address.
REQ-013 SHALL have ports read and write, each output, 1 bit: single-cycle SRAM command pulses.
REQ-014 SHALL have port byte_strb, output, STRB_WIDTH bits: SRAM byte enables.
REQ-015 SHALL have port wdata, output, DATA_WIDTH bits: SRAM write data.
REQ-016 SHALL have ports rdata (input, DATA_WIDTH bits) and rvalid (input, 1 bit), where the SRAM returns data registered one cycle after read.

Function
REQ-017 SHALL implement an FSM with states IDLE, WR, RD, RWAIT, DONE and ERR.
REQ-018 In IDLE, on psel=1 and penable=0 (setup phase), SHALL capture paddr, pwrite, pstrb and pwdata.
REQ-019 After capture, SHALL go to ERR if paddr[OFS-1:0] != 0, to WR if pwrite=1, and to RD otherwise.
REQ-020 On capture, SHALL register addr = paddr[ADDR_WIDTH+OFS-1:OFS] and wdata = pwdata.
REQ-021 On capture, SHALL register byte_strb = pstrb for writes and 0 for reads.
REQ-022 In WR, SHALL drive write=1 for exactly one cycle, then go to DONE.
REQ-023 A write with pstrb=0 SHALL still pulse write and complete with OKAY.
REQ-024 In RD, SHALL drive read=1 for exactly one cycle, clear the wait counter, then go to RWAIT.
REQ-025 In RWAIT, on rvalid=1, SHALL capture rdata into prdata and go to DONE.
REQ-026 In RWAIT, each cycle without rvalid SHALL increment the counter; at counter == TIMEOUT it SHALL go to ERR; the counter width is clog2(TIMEOUT+1).
REQ-027 In DONE, SHALL assert pready=1 and pslverr=0 for one cycle, then go to IDLE.
REQ-028 In ERR, SHALL assert pready=1 and pslverr=1 for one cycle, then go to IDLE.
REQ-029 pready and pslverr SHALL be 0 in all other states.
REQ-030 Cycle timing, with T0 = setup cycle: write gives write=1 at T1 and pready at T2; read gives read=1 at T1, rvalid expected at T2, pready at T3; misaligned gives pready=pslverr=1 at T1.
REQ-031 read and write SHALL never both be 1; no SRAM command SHALL be issued for a misaligned access.
REQ-032 rvalid SHALL be ignored outside RWAIT.
REQ-033 prdata SHALL hold the last successful read data; an errored read SHALL set prdata=0.
REQ-034 psel/penable changes after capture SHALL NOT abort the transfer; it runs to DONE or ERR.
REQ-035 A new setup phase SHALL be accepted only in IDLE.

Reset
REQ-036 While rstn=0, SHALL immediately force state=IDLE, counter=0, all outputs 0 (pready, pslverr, prdata, addr, read, write, byte_strb, wdata).
REQ-037 Reset mid-transfer SHALL abandon the transfer with no further SRAM command.
REQ-038 The first setup phase SHALL be accepted on the first rising edge with rstn=1.

Verification
REQ-039 SHALL cover: write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF -> addr=0x04, byte_strb=0xF, write=1 at T1, pready=1/pslverr=0 at T2.
REQ-040 SHALL cover: read paddr=0x10 against the SRAM model -> read=1 at T1, byte_strb=0, prdata=0xDEADBEEF with pready=1 at T3.
REQ-041 SHALL cover: write pstrb=0x2, pwdata=0x0000AB00 to 0x10, then read -> prdata=0xDEADABEF.
REQ-042 SHALL cover: read paddr=0x11 -> no read/write pulse, pready=1 and pslverr=1 at T1, prdata=0.
REQ-043 SHALL cover: rvalid tied 0 with TIMEOUT=15 -> pslverr=1 after 15 RWAIT cycles, then IDLE.
REQ-044 SHALL cover: rstn=0 asserted in RWAIT -> all outputs 0 immediately, a later rvalid is ignored, and the next transfer completes normally.
